// File: rtl/lutram_port_arbiter_pkg.sv
// Shared types and constants for the LUTRAM port arbiter slice.
// No logic; consumed by the top and the round-robin sub-module.
package lutram_port_arbiter_pkg;

  localparam int BYTE_LEN_IN_BITS = 8;

  typedef enum logic {
    IDLE  = 1'b0,
    FLUSH = 1'b1
  } flush_state_t;

  // Number of byte enables (all-ones mask width) for an entry of the given width.
  function automatic int write_mask_len(input int entry_width_in_bits);
    return entry_width_in_bits / BYTE_LEN_IN_BITS;
  endfunction

endpackage

// File: rtl/lutram_port_arbiter_rr.sv
// Round-robin arbiter: combinational one-hot grant from the first request at or after the pointer.
// Pointer moves to grant+1 only when the caller accepts the grant via advance.
module round_robin_arbiter #(
  parameter int NUM_REQUESTER = 4
) (
  input  logic                     clk_in,
  input  logic                     reset_in,
  input  logic [NUM_REQUESTER-1:0] request,
  input  logic                     advance,
  output logic [NUM_REQUESTER-1:0] grant
);

  localparam int IDX_W = (NUM_REQUESTER > 1) ? $clog2(NUM_REQUESTER) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REQUESTER - 1);

  logic [IDX_W-1:0] ptr_q;
  logic [IDX_W-1:0] ptr_d;
  logic [IDX_W-1:0] grant_idx;
  logic [IDX_W-1:0] idx;
  logic             found;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    idx       = '0;
    found     = 1'b0;
    for (int off = 0; off < NUM_REQUESTER; off++) begin
      idx = IDX_W'((int'(ptr_q) + off) % NUM_REQUESTER);
      if (!found && request[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        grant_idx  = idx;
      end
    end
    ptr_d = ptr_q;
    if (advance && found) begin
      ptr_d = (grant_idx == LAST_IDX) ? '0 : grant_idx + IDX_W'(1);
    end
  end

  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/lutram_port_arbiter.sv
// Shares one LUTRAM read port and one byte-masked write port among clients; a flush zero-fills every set.
// Commands reach ram_* one cycle after ack, read data returns two cycles after ack; clients cannot stall.
module lutram_port_arbiter
  import lutram_port_arbiter_pkg::*;
#(
  parameter int NUM_REQUESTER              = 4,
  parameter int SINGLE_ENTRY_WIDTH_IN_BITS = 64,
  parameter int NUM_SET                    = 64,
  parameter int SET_PTR_WIDTH_IN_BITS      = $clog2(NUM_SET) + 1,
  parameter int WRITE_MASK_LEN             = write_mask_len(SINGLE_ENTRY_WIDTH_IN_BITS)
) (
  input  logic                                                clk_in,
  input  logic                                                reset_in,
  input  logic [NUM_REQUESTER-1:0]                            request_valid_in,
  input  logic [NUM_REQUESTER-1:0]                            request_is_write_in,
  input  logic [NUM_REQUESTER*SET_PTR_WIDTH_IN_BITS-1:0]      request_addr_flatted_in,
  input  logic [NUM_REQUESTER*SINGLE_ENTRY_WIDTH_IN_BITS-1:0] request_data_flatted_in,
  input  logic [NUM_REQUESTER*WRITE_MASK_LEN-1:0]             request_write_mask_flatted_in,
  output logic [NUM_REQUESTER-1:0]                            request_ack_out,
  output logic [NUM_REQUESTER-1:0]                            response_valid_out,
  output logic [SINGLE_ENTRY_WIDTH_IN_BITS-1:0]               response_data_out,
  output logic                                                response_hit_out,
  input  logic                                                flush_in,
  output logic                                                flush_busy_out,
  output logic                                                ram_write_access_en_out,
  output logic [WRITE_MASK_LEN-1:0]                           ram_write_en_out,
  output logic [SET_PTR_WIDTH_IN_BITS-1:0]                    ram_write_set_addr_out,
  output logic [SINGLE_ENTRY_WIDTH_IN_BITS-1:0]               ram_write_data_out,
  output logic                                                ram_read_access_en_out,
  output logic [SET_PTR_WIDTH_IN_BITS-1:0]                    ram_read_set_addr_out,
  input  logic [SINGLE_ENTRY_WIDTH_IN_BITS-1:0]               ram_read_data_in,
  input  logic                                                ram_read_valid_in
);

  localparam int IDX_W = (NUM_REQUESTER > 1) ? $clog2(NUM_REQUESTER) : 1;
  localparam int CNT_W = (NUM_SET > 1) ? $clog2(NUM_SET) : 1;
  localparam logic [CNT_W-1:0]          LAST_SET  = CNT_W'(NUM_SET - 1);
  localparam logic [WRITE_MASK_LEN-1:0] FULL_MASK = {WRITE_MASK_LEN{1'b1}};

  typedef struct packed {
    logic                                  access;
    logic [WRITE_MASK_LEN-1:0]             mask;
    logic [SET_PTR_WIDTH_IN_BITS-1:0]      addr;
    logic [SINGLE_ENTRY_WIDTH_IN_BITS-1:0] data;
  } wr_cmd_t;

  logic [SET_PTR_WIDTH_IN_BITS-1:0]      req_addr [NUM_REQUESTER];
  logic [SINGLE_ENTRY_WIDTH_IN_BITS-1:0] req_data [NUM_REQUESTER];
  logic [WRITE_MASK_LEN-1:0]             req_mask [NUM_REQUESTER];

  for (genvar g = 0; g < NUM_REQUESTER; g++) begin : g_unflat
    assign req_addr[g] = request_addr_flatted_in[g*SET_PTR_WIDTH_IN_BITS +: SET_PTR_WIDTH_IN_BITS];
    assign req_data[g] = request_data_flatted_in[g*SINGLE_ENTRY_WIDTH_IN_BITS +: SINGLE_ENTRY_WIDTH_IN_BITS];
    assign req_mask[g] = request_write_mask_flatted_in[g*WRITE_MASK_LEN +: WRITE_MASK_LEN];
  end

  flush_state_t     state_q;
  flush_state_t     state_d;
  logic [CNT_W-1:0] flush_cnt_q;
  logic [CNT_W-1:0] flush_cnt_d;
  logic             flush_active;

  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      state_q     <= IDLE;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    flush_cnt_d  = flush_cnt_q;
    flush_active = 1'b0;
    case (state_q)
      IDLE: begin
        if (flush_in) state_d = FLUSH;
      end
      FLUSH: begin
        flush_active = 1'b1;
        if (flush_cnt_q == LAST_SET) begin
          flush_cnt_d = '0;
          state_d     = IDLE;
        end else begin
          flush_cnt_d = flush_cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign flush_busy_out = flush_active;

  logic [NUM_REQUESTER-1:0] wr_req;
  logic [NUM_REQUESTER-1:0] rd_req;
  logic [NUM_REQUESTER-1:0] wr_grant;
  logic [NUM_REQUESTER-1:0] rd_grant;
  logic [NUM_REQUESTER-1:0] rd_ack;
  logic                     rd_issue;

  // The flush owns the write port, so client writes are hidden from the write arbiter.
  assign wr_req = request_valid_in & request_is_write_in & ~{NUM_REQUESTER{flush_active}};
  assign rd_req = request_valid_in & ~request_is_write_in;

  round_robin_arbiter #(.NUM_REQUESTER(NUM_REQUESTER)) u_wr_arb (
    .clk_in   (clk_in),
    .reset_in (reset_in),
    .request  (wr_req),
    .advance  (|wr_grant),
    .grant    (wr_grant)
  );

  round_robin_arbiter #(.NUM_REQUESTER(NUM_REQUESTER)) u_rd_arb (
    .clk_in   (clk_in),
    .reset_in (reset_in),
    .request  (rd_req),
    .advance  (rd_issue),
    .grant    (rd_grant)
  );

  logic [IDX_W-1:0]                 wr_idx;
  logic [IDX_W-1:0]                 rd_idx;
  logic [SET_PTR_WIDTH_IN_BITS-1:0] rd_addr;
  logic                             wr_live;
  logic                             rd_collide;
  wr_cmd_t                          wr_cmd;

  always_comb begin
    wr_idx = '0;
    rd_idx = '0;
    for (int i = 0; i < NUM_REQUESTER; i++) begin
      if (wr_grant[i]) wr_idx = IDX_W'(i);
      if (rd_grant[i]) rd_idx = IDX_W'(i);
    end
  end

  always_comb begin
    wr_cmd  = '0;
    wr_live = 1'b0;
    if (flush_active) begin
      wr_live       = 1'b1;
      wr_cmd.access = 1'b1;
      wr_cmd.mask   = FULL_MASK;
      wr_cmd.addr   = SET_PTR_WIDTH_IN_BITS'(flush_cnt_q);
    end else if (|wr_grant) begin
      wr_live       = 1'b1;
      wr_cmd.access = |req_mask[wr_idx];
      wr_cmd.mask   = req_mask[wr_idx];
      wr_cmd.addr   = req_addr[wr_idx];
      wr_cmd.data   = req_data[wr_idx];
    end
    rd_addr = req_addr[rd_idx];
    // A partial write to the same set would race write-first forwarding; hold the read a cycle.
    rd_collide = wr_live && (|rd_grant) && (wr_cmd.addr == rd_addr) && (wr_cmd.mask != FULL_MASK);
    rd_issue   = (|rd_grant) && !rd_collide;
    rd_ack     = rd_issue ? rd_grant : '0;
  end

  assign request_ack_out = wr_grant | rd_ack;

  logic [NUM_REQUESTER-1:0] tag_q1;
  logic [NUM_REQUESTER-1:0] tag_q2;

  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      ram_write_access_en_out <= 1'b0;
      ram_write_en_out        <= '0;
      ram_write_set_addr_out  <= '0;
      ram_write_data_out      <= '0;
      ram_read_access_en_out  <= 1'b0;
      ram_read_set_addr_out   <= '0;
      tag_q1                  <= '0;
      tag_q2                  <= '0;
    end else begin
      ram_write_access_en_out <= wr_cmd.access;
      ram_write_en_out        <= wr_cmd.mask;
      ram_write_set_addr_out  <= wr_cmd.addr;
      ram_write_data_out      <= wr_cmd.data;
      ram_read_access_en_out  <= rd_issue;
      ram_read_set_addr_out   <= rd_issue ? rd_addr : '0;
      tag_q1                  <= rd_ack;
      tag_q2                  <= tag_q1;
    end
  end

  assign response_valid_out = tag_q2;
  assign response_data_out  = ram_read_data_in;
  assign response_hit_out   = ram_read_valid_in;

endmodule
